// File: rtl/fetch_queue.sv
// Circular fetch buffer between the IMEM stage and decode.
// Define FETCH_QUEUE_BYPASS_EN for a same-cycle bypass of an empty queue.
module fetch_queue #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FLUSH,
    input  logic                    in_valid,
    input  logic [DW-1:0]           in_instr,
    input  logic [AW-1:0]           in_pc,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_instr,
    output logic [AW-1:0]           out_pc,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] instr_q [DEPTH];
    logic [AW-1:0] pc_q    [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          q_valid;
    logic          push;
    logic          pop;
    logic          byp_take;

    assign q_valid  = (count_q != '0);
    assign in_ready = (count_q != CW'(DEPTH));
    assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp_en;

    // An empty queue forwards the incoming word straight to decode.
    assign byp_en    = !q_valid && in_valid && !FLUSH;
    assign byp_take  = byp_en && out_ready;
    assign out_valid = q_valid || byp_en;
    assign out_instr = byp_en ? in_instr : instr_q[head_q];
    assign out_pc    = byp_en ? in_pc    : pc_q[head_q];
`else
    assign byp_take  = 1'b0;
    assign out_valid = q_valid;
    assign out_instr = instr_q[head_q];
    assign out_pc    = pc_q[head_q];
`endif

    assign push = in_valid && in_ready && !FLUSH && !byp_take;
    assign pop  = q_valid && out_ready && !FLUSH;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (FLUSH) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                instr_q[tail_q] <= in_instr;
                pc_q[tail_q]    <= in_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random checks of fetch_queue against a queue-based model.
// Build with FETCH_QUEUE_BYPASS_EN defined to exercise the bypass path.
module tb_fetch_queue;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          FLUSH = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_instr = '0;
    logic [AW-1:0] in_pc = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } ent_t;

    ent_t mq[$];
    bit   zero_store = 1'b1;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs, advance model and clock.
    task automatic step(input logic rst, input logic flush,
                        input logic iv, input logic [DW-1:0] ins,
                        input logic [AW-1:0] pc, input logic ordy);
        bit   byp;
        bit   empty;
        bit   full;
        ent_t e;
        RST = rst; FLUSH = flush; in_valid = iv;
        in_instr = ins; in_pc = pc; out_ready = ordy;
        #1;
        empty = (mq.size() == 0);
        full  = (mq.size() == DEPTH);
        byp   = BYP && empty && iv && !flush;
        chk("in_ready", 32'(in_ready), 32'(!full));
        chk("out_valid", 32'(out_valid), 32'(!empty || byp));
        chk("count", 32'(count), 32'(mq.size()));
        if (!empty) begin
            chk("out_instr", out_instr, mq[0].ins);
            chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
        end else if (byp) begin
            chk("byp_instr", out_instr, ins);
            chk("byp_pc", 32'(out_pc), 32'(pc));
        end else if (zero_store) begin
            chk("rst_instr", out_instr, 32'h0);
            chk("rst_pc", 32'(out_pc), 32'h0);
        end
        if (rst) begin
            mq.delete();
            zero_store = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (!empty && ordy) void'(mq.pop_front());
            if (iv && !full && !(byp && ordy)) begin
                e.pc = pc;
                e.ins = ins;
                mq.push_back(e);
                zero_store = 1'b0;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        step(1, 0, 0, '0, '0, 0);
        step(0, 0, 0, 32'hDEAD_BEEF, 8'hAA, 0);
        // single push, one-cycle latency
        step(0, 0, 1, 32'h0000_0013, 8'h01, 0);
        step(0, 0, 0, '0, '0, 0);
        // fill, drop a word while full, then pop-only while full
        for (int i = 2; i <= 4; i++)
            step(0, 0, 1, 32'h100 + 32'(i), 8'(i), 0);
        step(0, 0, 1, 32'h0BAD, 8'h55, 0);
        step(0, 0, 1, 32'h0BAD, 8'h56, 1);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, '0, '0, 1);
        // flush with an incoming word
        step(0, 0, 1, 32'h201, 8'h21, 0);
        step(0, 0, 1, 32'h202, 8'h22, 0);
        step(0, 1, 1, 32'h203, 8'h23, 0);
        step(0, 0, 0, '0, '0, 0);
        // steady push+pop across pointer wrap
        step(0, 0, 1, 32'h303, 8'h03, 0);
        step(0, 0, 1, 32'h304, 8'h04, 0);
        for (int i = 5; i <= 14; i++)
            step(0, 0, 1, 32'h300 + 32'(i), 8'(i), 1);
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);
        // reset while non-empty
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 32'h400 + 32'(i), 8'(i + 'h40), 0);
        step(1, 1, 1, 32'h4FF, 8'h4F, 1);
        step(0, 0, 0, '0, '0, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
        step(0, 0, 1, 32'h00A0_0093, 8'h30, 1);
        step(0, 0, 0, '0, '0, 0);
        step(0, 0, 1, 32'h00A0_0113, 8'h31, 0);
        step(0, 0, 0, '0, '0, 1);
`endif
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(9) < 7), $urandom, 8'($urandom),
                 ($urandom_range(9) < 6));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DW, default 32, instruction word width.
REQ-002 SHALL have parameter AW, default 8, fetch address (PC) width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of two, 2..16.
REQ-004 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port FLUSH, input, 1, redirect (taken branch/jump); discards all queued entries.
REQ-007 SHALL have port in_valid, input, 1, the IMEM stage presents a fetched word this cycle.
REQ-008 SHALL have port in_instr, input, DW, fetched instruction word (IMEM data out).
REQ-009 SHALL have port in_pc, input, AW, address of in_instr (IMEM PC address out).
REQ-010 SHALL have port in_ready, output, 1, queue can accept a word this cycle.
REQ-011 SHALL have port out_valid, output, 1, head entry is valid for decode.
REQ-012 SHALL have port out_ready, input, 1, decode consumes the head this cycle.
REQ-013 SHALL have port out_instr, output, DW, head instruction.
REQ-014 SHALL have port out_pc, output, AW, head address.
REQ-015 SHALL have port count, output, log2(DEPTH)+1, number of occupied entries.

Function
REQ-016 SHALL implement a circular buffer of DEPTH entries {in_pc, in_instr} with head/tail pointers that wrap modulo DEPTH.
REQ-017 SHALL drive in_ready = (count != DEPTH), combinationally from registered state only; it SHALL not depend on out_ready (no push when full, even if a pop occurs in the same cycle).
REQ-018 SHALL push on an edge where in_valid && in_ready && !FLUSH: write the entry at tail, then tail+1.
REQ-019 SHALL pop on an edge where out_valid && out_ready && !FLUSH: head+1.
REQ-020 SHALL drive out_valid = (count != 0); out_instr/out_pc SHALL be the head entry, combinational read of registered storage.
REQ-021 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-022 SHALL make a word pushed at edge N visible on the outputs after edge N, i.e. a one-cycle minimum latency.
REQ-023 SHALL, on an edge with FLUSH=1, set head=tail=0 and count=0 and ignore any push or pop in that cycle; out_valid SHALL be 0 on the following cycle.
REQ-024 SHALL hold the outputs unchanged while out_valid=1 and out_ready=0.
REQ-025 SHALL treat in_instr and in_pc as don't-care when in_valid=0; storage SHALL not change.

Reset
REQ-026 SHALL, on a rising CLK edge with RST=1, clear head, tail, count and all storage entries to 0; RST SHALL override FLUSH, push and pop.
REQ-027 SHALL produce, after reset, out_valid=0, in_ready=1, count=0, out_instr=0 and out_pc=0.
REQ-028 SHALL discard all contents when RST is asserted mid-operation (while the queue is non-empty), with no entry surviving.

Configuration
REQ-029 SHALL, with FETCH_QUEUE_BYPASS_EN defined, bypass the queue when count==0, in_valid=1 and FLUSH=0: out_valid=1, out_instr=in_instr and out_pc=in_pc in the same cycle. If out_ready=1, the word SHALL be consumed and not stored (count stays 0); otherwise it SHALL be pushed normally.
REQ-030 SHALL, without FETCH_QUEUE_BYPASS_EN, keep out_valid purely registered, with the one-cycle latency of REQ-022.

Verification
REQ-031 SHALL cover: reset, then push (0x00000013, pc 0x01) with out_ready=0 -> next cycle out_valid=1, out_instr=0x00000013, out_pc=0x01, count=1.
REQ-032 SHALL cover: 4 pushes with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is dropped; 4 pops then return the words in push order.
REQ-033 SHALL cover: full queue, in_valid=1 and out_ready=1 in the same cycle -> pop only, count 4->3, in_ready=1 on the next cycle.
REQ-034 SHALL cover: count=2, FLUSH=1 with in_valid=1 -> count=0, out_valid=0 on the next cycle; the flushed-cycle word is not queued.
REQ-035 SHALL cover: steady push+pop for 10 cycles across pointer wrap -> count constant, in-order data, pc 0x05..0x0E.
REQ-036 SHALL cover: with FETCH_QUEUE_BYPASS_EN defined, empty queue, in_valid=1, out_ready=1, in_instr=0x00A00093 -> same-cycle out_valid=1, out_instr=0x00A00093, count stays 0.
